// File: rtl/wb_mem_ctrl.sv
// rtl/wb_mem_ctrl.sv - single-port RAM scheduler for the Wishbone data and instruction buses
// Optional instruction-aging grant override: define WB_MEM_AGING_EN.
`timescale 1ns/1ps
module wb_mem_ctrl #(
  parameter int DW        = 32,
  parameter int AW        = 16,
  parameter int RAM_AW    = 12,
  parameter int AGE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_adr,
  input  logic [DW-1:0]     wb_dat_i,
  output logic [DW-1:0]     wb_dat_o,
  output logic              wb_ack,
  input  logic              wb_inst_cyc,
  input  logic              wb_inst_stb,
  input  logic [AW-1:0]     wb_inst_pc,
  output logic [DW-1:0]     wb_inst_o,
  output logic              wb_inst_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DW-1:0]     ram_wdata,
  input  logic [DW-1:0]     ram_rdata,
  output logic              oor_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic          gnt_inst;
  logic          rd_q;
  logic          oor_q;
  logic [DW-1:0] dat_q;
  logic [DW-1:0] inst_q;

  logic          data_v;
  logic          inst_v;
  logic          take_inst;
  logic [AW-1:0] req_adr;
  logic          req_oor;
  logic [DW-1:0] rd_val;

  assign data_v  = wb_cyc & wb_stb;
  assign inst_v  = wb_inst_cyc & wb_inst_stb;
  assign req_adr = take_inst ? wb_inst_pc : wb_adr;

  generate
    if (RAM_AW < AW) begin : g_oor
      assign req_oor = |req_adr[AW-1:RAM_AW];
    end else begin : g_no_oor
      assign req_oor = 1'b0;
    end
  endgenerate

`ifdef WB_MEM_AGING_EN
  logic [7:0] age_cnt;

  assign take_inst = inst_v & (~data_v | (age_cnt >= 8'(AGE_LIMIT)));

  // Counts IDLE decisions the fetch lost to data; saturates rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_cnt <= 8'd0;
    end else if (state == IDLE) begin
      if (take_inst)
        age_cnt <= 8'd0;
      else if (inst_v && age_cnt != 8'hff)
        age_cnt <= age_cnt + 8'd1;
    end
  end
`else
  assign take_inst = inst_v & ~data_v;
`endif

  // Synchronous RAM data only exists during RESP, so it is forwarded there
  // and the registered copy holds it afterwards.
  assign rd_val    = oor_q ? '0 : ram_rdata;
  assign wb_dat_o  = (state == RESP && rd_q && !gnt_inst) ? rd_val : dat_q;
  assign wb_inst_o = (state == RESP && rd_q &&  gnt_inst) ? rd_val : inst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt_inst    <= 1'b0;
      rd_q        <= 1'b0;
      oor_q       <= 1'b0;
      dat_q       <= '0;
      inst_q      <= '0;
      wb_ack      <= 1'b0;
      wb_inst_ack <= 1'b0;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      oor_err     <= 1'b0;
    end else begin
      wb_ack      <= 1'b0;
      wb_inst_ack <= 1'b0;
      oor_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (data_v || inst_v) begin
            state     <= ACCESS;
            gnt_inst  <= take_inst;
            rd_q      <= take_inst | ~wb_we;
            oor_q     <= req_oor;
            ram_en    <= ~req_oor;
            ram_we    <= ~take_inst & wb_we & ~req_oor;
            ram_addr  <= req_adr[RAM_AW-1:0];
            ram_wdata <= wb_dat_i;
          end
        end
        ACCESS: begin
          state   <= RESP;
          ram_en  <= 1'b0;
          ram_we  <= 1'b0;
          oor_err <= oor_q;
          // A requester that let go of cyc has abandoned the cycle: no ack.
          if (gnt_inst)
            wb_inst_ack <= wb_inst_cyc;
          else
            wb_ack <= wb_cyc;
        end
        RESP: begin
          state <= IDLE;
          if (rd_q) begin
            if (gnt_inst)
              inst_q <= rd_val;
            else
              dat_q <= rd_val;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_ctrl.sv
// tb/tb_wb_mem_ctrl.sv - directed self-checking bench for wb_mem_ctrl with a behavioural RAM
`timescale 1ns/1ps
module tb_wb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_cyc, wb_stb, wb_we;
  logic [15:0] wb_adr;
  logic [31:0] wb_dat_i, wb_dat_o;
  logic        wb_ack;
  logic        wb_inst_cyc, wb_inst_stb;
  logic [15:0] wb_inst_pc;
  logic [31:0] wb_inst_o;
  logic        wb_inst_ack;
  logic        ram_en, ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        oor_err;

  logic        bd_we;
  logic [11:0] bd_addr;
  logic [31:0] bd_data;
  logic [31:0] mem [0:4095];

  int passed = 0;
  int total  = 0;
  int first_ack;
  int exp_ack;

  always #5 clk = ~clk;

  wb_mem_ctrl #(.DW(32), .AW(16), .RAM_AW(12), .AGE_LIMIT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
    .wb_inst_cyc(wb_inst_cyc), .wb_inst_stb(wb_inst_stb), .wb_inst_pc(wb_inst_pc),
    .wb_inst_o(wb_inst_o), .wb_inst_ack(wb_inst_ack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .oor_err(oor_err)
  );

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
  endtask

  task automatic req_data(input logic we, input logic [15:0] a, input logic [31:0] d);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = a; wb_dat_i = d;
  endtask

  task automatic drop_data();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic req_inst(input logic [15:0] pc);
    wb_inst_cyc = 1'b1; wb_inst_stb = 1'b1; wb_inst_pc = pc;
  endtask

  task automatic drop_inst();
    wb_inst_cyc = 1'b0; wb_inst_stb = 1'b0;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
  endtask

  initial begin
    rst_n = 1'b0;
    drop_data(); wb_adr = '0; wb_dat_i = '0;
    drop_inst(); wb_inst_pc = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;

    preload(12'h020, 32'h12345678);
    preload(12'h004, 32'hAAAA0004);
    preload(12'h008, 32'hBBBB0008);
    preload(12'h030, 32'h0BADF00D);
    @(negedge clk);
    bd_we = 1'b0;

    chk("rst_wb_ack", {31'd0, wb_ack}, 32'd0);
    chk("rst_inst_ack", {31'd0, wb_inst_ack}, 32'd0);
    chk("rst_dat_o", wb_dat_o, 32'd0);
    chk("rst_inst_o", wb_inst_o, 32'd0);
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", {20'd0, ram_addr}, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_oor_err", {31'd0, oor_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // data write 0x0010
    req_data(1'b1, 16'h0010, 32'hDEADBEEF);
    @(negedge clk);
    wb_dat_i = 32'h0;
    chk("wr_ram_en", {31'd0, ram_en}, 32'd1);
    chk("wr_ram_we", {31'd0, ram_we}, 32'd1);
    chk("wr_ram_addr", {20'd0, ram_addr}, 32'h010);
    chk("wr_ram_wdata", ram_wdata, 32'hDEADBEEF);
    chk("wr_ack_early", {31'd0, wb_ack}, 32'd0);
    @(negedge clk);
    chk("wr_ack", {31'd0, wb_ack}, 32'd1);
    chk("wr_ram_we_off", {31'd0, ram_we}, 32'd0);
    chk("wr_oor", {31'd0, oor_err}, 32'd0);
    drop_data();
    @(negedge clk);
    chk("wr_ack_off", {31'd0, wb_ack}, 32'd0);
    chk("wr_mem", mem[12'h010], 32'hDEADBEEF);

    // data read 0x0010
    req_data(1'b0, 16'h0010, 32'h0);
    @(negedge clk);
    chk("rd_ram_en", {31'd0, ram_en}, 32'd1);
    chk("rd_ram_we", {31'd0, ram_we}, 32'd0);
    @(negedge clk);
    chk("rd_ack", {31'd0, wb_ack}, 32'd1);
    chk("rd_dat", wb_dat_o, 32'hDEADBEEF);
    drop_data();
    @(negedge clk);
    chk("rd_ack_off", {31'd0, wb_ack}, 32'd0);
    chk("rd_dat_hold", wb_dat_o, 32'hDEADBEEF);

    // fetch 0x0020
    req_inst(16'h0020);
    @(negedge clk);
    chk("if_ram_en", {31'd0, ram_en}, 32'd1);
    chk("if_ram_addr", {20'd0, ram_addr}, 32'h020);
    @(negedge clk);
    chk("if_ack", {31'd0, wb_inst_ack}, 32'd1);
    chk("if_data", wb_inst_o, 32'h12345678);
    chk("if_no_dack", {31'd0, wb_ack}, 32'd0);
    drop_inst();
    @(negedge clk);
    chk("if_ack_off", {31'd0, wb_inst_ack}, 32'd0);
    chk("if_dat_o_kept", wb_dat_o, 32'hDEADBEEF);

    // simultaneous data read 0x0004 and fetch 0x0008
    req_data(1'b0, 16'h0004, 32'h0);
    req_inst(16'h0008);
    @(negedge clk);
    chk("sim_c1_addr", {20'd0, ram_addr}, 32'h004);
    @(negedge clk);
    chk("sim_c2_dack", {31'd0, wb_ack}, 32'd1);
    chk("sim_c2_dat", wb_dat_o, 32'hAAAA0004);
    chk("sim_c2_iack", {31'd0, wb_inst_ack}, 32'd0);
    drop_data();
    @(negedge clk);
    chk("sim_c3_iack", {31'd0, wb_inst_ack}, 32'd0);
    @(negedge clk);
    chk("sim_c4_en", {31'd0, ram_en}, 32'd1);
    chk("sim_c4_addr", {20'd0, ram_addr}, 32'h008);
    @(negedge clk);
    chk("sim_c5_iack", {31'd0, wb_inst_ack}, 32'd1);
    chk("sim_c5_inst", wb_inst_o, 32'hBBBB0008);
    drop_inst();
    @(negedge clk);

    // out-of-range read 0x1000
    req_data(1'b0, 16'h1000, 32'h0);
    @(negedge clk);
    chk("oor_ram_en", {31'd0, ram_en}, 32'd0);
    @(negedge clk);
    chk("oor_ack", {31'd0, wb_ack}, 32'd1);
    chk("oor_dat", wb_dat_o, 32'd0);
    chk("oor_err", {31'd0, oor_err}, 32'd1);
    drop_data();
    @(negedge clk);
    chk("oor_err_off", {31'd0, oor_err}, 32'd0);

    // abandoned read: cyc dropped during ACCESS
    req_data(1'b0, 16'h0010, 32'h0);
    @(negedge clk);
    chk("abn_ram_en", {31'd0, ram_en}, 32'd1);
    drop_data();
    @(negedge clk);
    chk("abn_no_ack", {31'd0, wb_ack}, 32'd0);
    @(negedge clk);

    // reset during ACCESS of a write to 0x0030
    req_data(1'b1, 16'h0030, 32'h11111111);
    @(negedge clk);
    chk("rw_access_we", {31'd0, ram_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rw_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rw_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rw_ram_wdata", ram_wdata, 32'd0);
    drop_data();
    @(negedge clk);
    chk("rw_ack", {31'd0, wb_ack}, 32'd0);
    chk("rw_mem_kept", mem[12'h030], 32'h0BADF00D);
    rst_n = 1'b1;
    @(negedge clk);
    req_data(1'b0, 16'h0030, 32'h0);
    @(negedge clk);
    chk("rw_idle_en", {31'd0, ram_en}, 32'd1);
    @(negedge clk);
    chk("rw_rd_ack", {31'd0, wb_ack}, 32'd1);
    chk("rw_rd_dat", wb_dat_o, 32'h0BADF00D);
    drop_data();
    @(negedge clk);

    // continuous data requests with a pending fetch
    first_ack = -1;
    req_data(1'b0, 16'h0004, 32'h0);
    req_inst(16'h0008);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (wb_inst_ack === 1'b1 && first_ack < 0) begin
        first_ack = c;
        drop_inst();
      end
    end
`ifdef WB_MEM_AGING_EN
    exp_ack = 8;
`else
    exp_ack = -1;
`endif
    chk("age_ack_cycle", first_ack, exp_ack);
    drop_data();
    drop_inst();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
